// File: rtl/midi_voice_alloc_if.sv
// Note-event bus from the MIDI parser into the voice allocator.
interface midi_voice_alloc_if;
  logic       note_on;
  logic       note_off;
  logic [6:0] note_number;
  logic [6:0] velocity;

  modport master (output note_on, output note_off, output note_number, output velocity);
  modport slave  (input  note_on, input  note_off, input  note_number, input  velocity);
endinterface

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: note-to-voice assignment, delay/divider lookup, burst/ring/release sequencing.
// Optional build macro VOICE_STEAL_EN enables round-robin voice stealing when every voice is busy.
module midi_voice_alloc #(
  parameter int unsigned NUM_VOICES  = 12,
  parameter int unsigned DELAY_W     = 10,
  parameter int unsigned RELEASE_LEN = 1024
) (
  input  logic                          a_clk,
  input  logic                          reset_n,
  midi_voice_alloc_if.slave             bus,
  input  logic [NUM_VOICES-1:0]         i_voice_tick,
  input  logic [16*NUM_VOICES-1:0]      i_noise_in,
  output logic [2*NUM_VOICES-1:0]       o_voice_state,
  output logic [7*NUM_VOICES-1:0]       o_voice_note,
  output logic [DELAY_W*NUM_VOICES-1:0] o_voice_delay,
  output logic [4*NUM_VOICES-1:0]       o_voice_div,
  output logic [24*NUM_VOICES-1:0]      o_voice_excite,
  output logic [NUM_VOICES-1:0]         o_voice_damp,
  output logic                          o_drop_pulse
);
  localparam int unsigned REL_W = $clog2(RELEASE_LEN + 1);
  localparam int unsigned CNT_W = (DELAY_W > REL_W) ? DELAY_W : REL_W;
  localparam int unsigned VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST   = 2'd1,
    S_RING    = 2'd2,
    S_RELEASE = 2'd3
  } voice_state_e;

  voice_state_e        r_state  [NUM_VOICES];
  logic [6:0]          r_note   [NUM_VOICES];
  logic [DELAY_W-1:0]  r_delay  [NUM_VOICES];
  logic [3:0]          r_div    [NUM_VOICES];
  logic [6:0]          r_vel    [NUM_VOICES];
  logic [CNT_W-1:0]    r_cnt    [NUM_VOICES];
  logic signed [23:0]  r_excite [NUM_VOICES];
  logic                r_drop;

  voice_state_e        w_state_nxt  [NUM_VOICES];
  logic [CNT_W-1:0]    w_cnt_nxt    [NUM_VOICES];
  logic signed [23:0]  w_excite_nxt [NUM_VOICES];
  logic signed [23:0]  w_prod       [NUM_VOICES];

  logic [3:0]          w_pc, w_oct;
  logic [9:0]          w_base;
  logic [DELAY_W-1:0]  w_new_delay;
  logic [3:0]          w_new_div;

  logic                w_on, w_off, w_match_hit, w_idle_hit;
  logic                w_alloc, w_release, w_drop;
  logic [VI_W-1:0]     w_match_idx, w_idle_idx, w_alloc_idx;
`ifdef VOICE_STEAL_EN
  logic [VI_W-1:0]     r_steal;
  logic                w_steal;
`endif

  always_comb begin
    w_pc  = 4'(bus.note_number % 7'd12);
    w_oct = 4'(bus.note_number / 7'd12);
    case (w_pc)
      4'd0:    w_base = 10'd734;
      4'd1:    w_base = 10'd693;
      4'd2:    w_base = 10'd654;
      4'd3:    w_base = 10'd617;
      4'd4:    w_base = 10'd582;
      4'd5:    w_base = 10'd550;
      4'd6:    w_base = 10'd519;
      4'd7:    w_base = 10'd490;
      4'd8:    w_base = 10'd462;
      4'd9:    w_base = 10'd436;
      4'd10:   w_base = 10'd412;
      default: w_base = 10'd389;
    endcase
    // Top octave runs at full a_clk, so the delay is halved (rounded) instead of dividing further.
    if (w_oct == 4'd10) begin
      w_new_delay = DELAY_W'((11'(w_base) + 11'd1) >> 1);
      w_new_div   = '0;
    end else begin
      w_new_delay = DELAY_W'(w_base);
      w_new_div   = 4'd9 - w_oct;
    end
  end

  always_comb begin
    w_on        = bus.note_on && (bus.velocity != '0);
    w_off       = !w_on && (bus.note_off || bus.note_on);
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_idle_hit  = 1'b0;
    w_idle_idx  = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!w_match_hit && r_state[v] != S_IDLE && r_note[v] == bus.note_number) begin
        w_match_hit = 1'b1;
        w_match_idx = VI_W'(v);
      end
      if (!w_idle_hit && r_state[v] == S_IDLE) begin
        w_idle_hit = 1'b1;
        w_idle_idx = VI_W'(v);
      end
    end
    w_alloc     = 1'b0;
    w_alloc_idx = '0;
    w_drop      = 1'b0;
`ifdef VOICE_STEAL_EN
    w_steal     = 1'b0;
`endif
    if (w_on) begin
      if (w_match_hit) begin
        w_alloc     = 1'b1;
        w_alloc_idx = w_match_idx;
      end else if (w_idle_hit) begin
        w_alloc     = 1'b1;
        w_alloc_idx = w_idle_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        w_alloc     = 1'b1;
        w_alloc_idx = r_steal;
        w_steal     = 1'b1;
`else
        w_drop      = 1'b1;
`endif
      end
    end
    w_release = w_off && w_match_hit && (r_state[w_match_idx] != S_RELEASE);
  end

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      w_prod[v]       = 24'($signed(i_noise_in[16*v +: 16])) * 24'($signed({1'b0, r_vel[v]}));
      w_state_nxt[v]  = r_state[v];
      w_cnt_nxt[v]    = r_cnt[v];
      w_excite_nxt[v] = r_excite[v];
      if (w_alloc && w_alloc_idx == VI_W'(v)) begin
        w_state_nxt[v] = S_BURST;
        w_cnt_nxt[v]   = CNT_W'(w_new_delay);
      end else if (w_release && w_match_idx == VI_W'(v)) begin
        w_state_nxt[v]  = S_RELEASE;
        w_cnt_nxt[v]    = CNT_W'(RELEASE_LEN);
        w_excite_nxt[v] = '0;
      end else if (i_voice_tick[v]) begin
        case (r_state[v])
          S_BURST: begin
            if (r_cnt[v] <= CNT_W'(1)) begin
              w_state_nxt[v]  = S_RING;
              w_cnt_nxt[v]    = '0;
              w_excite_nxt[v] = '0;
            end else begin
              w_cnt_nxt[v]    = r_cnt[v] - CNT_W'(1);
              w_excite_nxt[v] = w_prod[v];
            end
          end
          S_RELEASE: begin
            if (r_cnt[v] <= CNT_W'(1)) begin
              w_state_nxt[v] = S_IDLE;
              w_cnt_nxt[v]   = '0;
            end else begin
              w_cnt_nxt[v]   = r_cnt[v] - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_state[v]  <= S_IDLE;
        r_note[v]   <= '0;
        r_delay[v]  <= DELAY_W'(734);
        r_div[v]    <= '0;
        r_vel[v]    <= '0;
        r_cnt[v]    <= '0;
        r_excite[v] <= '0;
      end
      r_drop <= 1'b0;
`ifdef VOICE_STEAL_EN
      r_steal <= '0;
`endif
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_state[v]  <= w_state_nxt[v];
        r_cnt[v]    <= w_cnt_nxt[v];
        r_excite[v] <= w_excite_nxt[v];
        if (w_alloc && w_alloc_idx == VI_W'(v)) begin
          r_note[v]  <= bus.note_number;
          r_delay[v] <= w_new_delay;
          r_div[v]   <= w_new_div;
          r_vel[v]   <= bus.velocity;
        end
      end
      r_drop <= w_drop;
`ifdef VOICE_STEAL_EN
      if (w_steal) r_steal <= (r_steal == VI_W'(NUM_VOICES - 1)) ? '0 : r_steal + VI_W'(1);
`endif
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      o_voice_state[2*v +: 2]             = r_state[v];
      o_voice_note[7*v +: 7]              = r_note[v];
      o_voice_delay[DELAY_W*v +: DELAY_W] = r_delay[v];
      o_voice_div[4*v +: 4]               = r_div[v];
      o_voice_excite[24*v +: 24]          = r_excite[v];
      o_voice_damp[v]                     = (r_state[v] == S_RELEASE);
    end
  end

  assign o_drop_pulse = r_drop;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed vector bench for midi_voice_alloc; honours VOICE_STEAL_EN to match the DUT build.
module tb_midi_voice_alloc;
  localparam int unsigned NV = 12;

  typedef struct {
    logic       on;
    logic       off;
    logic [6:0] note;
    logic [6:0] vel;
    int         v;
    int         st;
    int         dly;
    int         dv;
    int         damp;
    int         busy;
  } vec_t;

  logic a_clk   = 1'b0;
  logic reset_n = 1'b0;
  logic [NV-1:0]      tick  = '0;
  logic [16*NV-1:0]   noise = '0;
  logic [2*NV-1:0]    voice_state;
  logic [7*NV-1:0]    voice_note;
  logic [10*NV-1:0]   voice_delay;
  logic [4*NV-1:0]    voice_div;
  logic [24*NV-1:0]   voice_excite;
  logic [NV-1:0]      voice_damp;
  logic               drop_pulse;

  midi_voice_alloc_if bus ();

  midi_voice_alloc #(.NUM_VOICES(NV), .DELAY_W(10), .RELEASE_LEN(1024)) dut (
    .a_clk          (a_clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .i_voice_tick   (tick),
    .i_noise_in     (noise),
    .o_voice_state  (voice_state),
    .o_voice_note   (voice_note),
    .o_voice_delay  (voice_delay),
    .o_voice_div    (voice_div),
    .o_voice_excite (voice_excite),
    .o_voice_damp   (voice_damp),
    .o_drop_pulse   (drop_pulse)
  );

  always #5 a_clk = ~a_clk;

  int checks   = 0;
  int failures = 0;
  vec_t tbl [16];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int st(input int v);   return int'(voice_state[2*v +: 2]);  endfunction
  function automatic int nt(input int v);   return int'(voice_note[7*v +: 7]);   endfunction
  function automatic int dl(input int v);   return int'(voice_delay[10*v +: 10]); endfunction
  function automatic int dvs(input int v);  return int'(voice_div[4*v +: 4]);    endfunction
  function automatic longint ex(input int v);
    logic signed [23:0] e;
    e = voice_excite[24*v +: 24];
    return longint'(e);
  endfunction
  function automatic int nbusy();
    int n = 0;
    for (int v = 0; v < NV; v++) if (voice_state[2*v +: 2] != 2'd0) n++;
    return n;
  endfunction

  function automatic vec_t mk(input logic on, input logic off, input logic [6:0] note,
                              input logic [6:0] vel, input int v, input int s, input int d,
                              input int dv, input int dmp, input int busy);
    vec_t r;
    r.on = on; r.off = off; r.note = note; r.vel = vel; r.v = v;
    r.st = s; r.dly = d; r.dv = dv; r.damp = dmp; r.busy = busy;
    return r;
  endfunction

  task automatic send(input logic on, input logic off, input logic [6:0] note, input logic [6:0] vel);
    @(negedge a_clk);
    bus.note_on = on; bus.note_off = off; bus.note_number = note; bus.velocity = vel;
    @(negedge a_clk);
    bus.note_on = 1'b0; bus.note_off = 1'b0;
  endtask

  task automatic ticks(input int v, input int n);
    @(negedge a_clk);
    tick = NV'(1) << v;
    repeat (n) @(negedge a_clk);
    tick = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.note_on = 1'b0; bus.note_off = 1'b0; bus.note_number = '0; bus.velocity = '0;
    tbl[0]  = mk(1'b1, 1'b0, 7'd60,  7'd100, 0,  1, 734, 4, 0, 1);
    tbl[1]  = mk(1'b1, 1'b0, 7'd120, 7'd127, 1,  1, 367, 0, 0, 2);
    tbl[2]  = mk(1'b1, 1'b0, 7'd126, 7'd10,  2,  1, 260, 0, 0, 3);
    tbl[3]  = mk(1'b1, 1'b0, 7'd8,   7'd50,  3,  1, 462, 9, 0, 4);
    tbl[4]  = mk(1'b1, 1'b0, 7'd64,  7'd80,  4,  1, 582, 4, 0, 5);
    tbl[5]  = mk(1'b1, 1'b0, 7'd64,  7'd90,  4,  1, 582, 4, 0, 5);
    tbl[6]  = mk(1'b1, 1'b1, 7'd50,  7'd60,  5,  1, 654, 5, 0, 6);
    tbl[7]  = mk(1'b0, 1'b1, 7'd99,  7'd0,   5,  1, 654, 5, 0, 6);
    tbl[8]  = mk(1'b1, 1'b0, 7'd64,  7'd0,   4,  3, 582, 4, 1, 6);
    tbl[9]  = mk(1'b1, 1'b0, 7'd64,  7'd70,  4,  1, 582, 4, 0, 6);
    tbl[10] = mk(1'b1, 1'b0, 7'd127, 7'd1,   6,  1, 245, 0, 0, 7);
    tbl[11] = mk(1'b1, 1'b0, 7'd0,   7'd1,   7,  1, 734, 9, 0, 8);
    tbl[12] = mk(1'b1, 1'b0, 7'd70,  7'd30,  8,  1, 412, 4, 0, 9);
    tbl[13] = mk(1'b1, 1'b0, 7'd71,  7'd30,  9,  1, 389, 4, 0, 10);
    tbl[14] = mk(1'b1, 1'b0, 7'd72,  7'd30,  10, 1, 734, 3, 0, 11);
    tbl[15] = mk(1'b1, 1'b0, 7'd73,  7'd30,  11, 1, 693, 3, 0, 12);

    repeat (3) @(negedge a_clk);
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("reset v%0d state", v), st(v), 0);
      chk($sformatf("reset v%0d note", v), nt(v), 0);
      chk($sformatf("reset v%0d delay", v), dl(v), 734);
      chk($sformatf("reset v%0d div", v), dvs(v), 0);
      chk($sformatf("reset v%0d excite", v), ex(v), 0);
      chk($sformatf("reset v%0d damp", v), voice_damp[v], 0);
    end
    chk("reset drop", drop_pulse, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      send(tbl[i].on, tbl[i].off, tbl[i].note, tbl[i].vel);
      chk($sformatf("row%0d state", i), st(tbl[i].v), tbl[i].st);
      chk($sformatf("row%0d note", i), nt(tbl[i].v), tbl[i].off && !tbl[i].on ? 50 : int'(tbl[i].note));
      chk($sformatf("row%0d delay", i), dl(tbl[i].v), tbl[i].dly);
      chk($sformatf("row%0d div", i), dvs(tbl[i].v), tbl[i].dv);
      chk($sformatf("row%0d damp", i), voice_damp[tbl[i].v], tbl[i].damp);
      chk($sformatf("row%0d busy", i), nbusy(), tbl[i].busy);
      chk($sformatf("row%0d drop", i), drop_pulse, 0);
    end

    // Voice 0 (note 60, vel 100): full 734-tick burst with excite hold between ticks.
    noise[15:0] = 16'h0100;
    ticks(0, 1);
    chk("v0 excite first tick", ex(0), 25600);
    noise[15:0] = 16'h0200;
    repeat (2) @(negedge a_clk);
    chk("v0 excite held", ex(0), 25600);
    ticks(0, 732);
    chk("v0 burst at 733", st(0), 1);
    chk("v0 excite 733", ex(0), 51200);
    ticks(0, 1);
    chk("v0 ring at 734", st(0), 2);
    chk("v0 excite ring", ex(0), 0);

    // Negative noise sample, vel 50.
    noise[48 +: 16] = 16'hFF00;
    ticks(3, 1);
    chk("v3 excite negative", ex(3), -12800);

    // Retrigger reloads the burst counter to 582.
    ticks(4, 100);
    send(1'b1, 1'b0, 7'd64, 7'd70);
    chk("v4 retrig state", st(4), 1);
    chk("v4 retrig busy", nbusy(), 12);
    ticks(4, 581);
    chk("v4 burst at 581", st(4), 1);
    ticks(4, 1);
    chk("v4 ring at 582", st(4), 2);

    // Release of voice 8 with a repeated note_off that must not restart the countdown.
    send(1'b0, 1'b1, 7'd70, 7'd0);
    chk("v8 release state", st(8), 3);
    chk("v8 damp", voice_damp[8], 1);
    ticks(8, 500);
    send(1'b0, 1'b1, 7'd70, 7'd0);
    chk("v8 second off", st(8), 3);
    ticks(8, 523);
    chk("v8 release at 1023", st(8), 3);
    ticks(8, 1);
    chk("v8 idle at 1024", st(8), 0);
    chk("v8 damp low", voice_damp[8], 0);

    send(1'b1, 1'b0, 7'd80, 7'd60);
    chk("refill v8 note", nt(8), 80);
    chk("refill v8 delay", dl(8), 462);
    chk("refill v8 div", dvs(8), 3);
    chk("refill busy", nbusy(), 12);

    // All voices busy: steal or drop.
    send(1'b1, 1'b0, 7'd90, 7'd40);
`ifdef VOICE_STEAL_EN
    chk("steal1 drop", drop_pulse, 0);
    chk("steal1 v0 note", nt(0), 90);
    chk("steal1 v0 state", st(0), 1);
    send(1'b1, 1'b0, 7'd91, 7'd40);
    chk("steal2 v1 note", nt(1), 91);
    chk("steal2 v1 state", st(1), 1);
    chk("steal2 v0 note", nt(0), 90);
`else
    chk("drop pulse high", drop_pulse, 1);
    chk("drop v0 note", nt(0), 60);
    chk("drop v0 state", st(0), 2);
    @(negedge a_clk);
    chk("drop pulse low", drop_pulse, 0);
    send(1'b1, 1'b0, 7'd91, 7'd40);
    chk("drop2 pulse", drop_pulse, 1);
    chk("drop2 v1 note", nt(1), 120);
`endif
    chk("full busy", nbusy(), 12);

    // Reset mid-burst on voice 2, with a note_on strobe that must be lost.
    noise[32 +: 16] = 16'h0010;
    ticks(2, 3);
    chk("v2 excite pre-reset", ex(2), 160);
    @(negedge a_clk);
    reset_n = 1'b0;
    bus.note_on = 1'b1; bus.note_number = 7'd60; bus.velocity = 7'd100;
    @(negedge a_clk);
    chk("mid reset busy", nbusy(), 0);
    chk("mid reset v2 excite", ex(2), 0);
    chk("mid reset damp", voice_damp, 0);
    bus.note_on = 1'b0;
    reset_n = 1'b1;
    @(negedge a_clk);
    chk("post reset v0 state", st(0), 0);
    chk("post reset busy", nbusy(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
